// File: rtl/mac_vec_out_pkg.sv
// Shared constants and helpers for the matrix-vector MAC output stage,
// used by this stage, its output FIFO and the datapath top level.
package mac_vec_out_pkg;

  localparam int DEF_INW   = 14;
  localparam int DEF_OUTW  = 48;
  localparam int DEF_K     = 8;
  localparam int DEF_DEPTH = 17;

  // Pipeline flags that travel alongside the registered product.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } prod_flags_t;

  function automatic int cap_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mac_vec_out_if.sv
// Element-pair input stream plus the output FIFO write/credit port of the
// MAC stage. The slave modport is the MAC's view, master is its environment.
interface mac_vec_out_if
  import mac_vec_out_pkg::*;
#(
  parameter int INW   = DEF_INW,
  parameter int OUTW  = DEF_OUTW,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CAPW = cap_width(DEPTH);

  logic [INW-1:0]  x_data;
  logic [INW-1:0]  w_data;
  logic            in_valid;
  logic            in_ready;
  logic [CAPW-1:0] fifo_capacity;
  logic [OUTW-1:0] fifo_data;
  logic            fifo_wr_en;

  modport master (
    output x_data, w_data, in_valid, fifo_capacity,
    input  in_ready, fifo_data, fifo_wr_en
  );

  modport slave (
    input  x_data, w_data, in_valid, fifo_capacity,
    output in_ready, fifo_data, fifo_wr_en
  );

endinterface

// File: rtl/mac_credit_ctrl.sv
// Element counter and FIFO credit tracking for the MAC stage; only vector
// starts are gated on credit, a started vector always runs to completion.
module mac_credit_ctrl #(
  parameter int K    = 8,
  parameter int CAPW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            fifo_wr_en,
  input  logic [CAPW-1:0] fifo_capacity,
  output logic            in_ready,
  output logic            accept,
  output logic            first,
  output logic            last
);

  localparam int CNTW = (K > 1) ? $clog2(K) : 1;
  localparam int CMPW = (CAPW > 2) ? CAPW : 2;
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(K - 1);

  logic [CNTW-1:0] cnt;
  logic [1:0]      pending;

  assign first    = (cnt == '0);
  assign last     = (cnt == LAST_IDX);
  assign in_ready = !first || (CMPW'(fifo_capacity) > CMPW'(pending));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + CNTW'(1);
    end
  end

  // pending = vectors started but not yet written; it mirrors what the FIFO
  // has not yet subtracted from its capacity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      case ({accept && first, fifo_wr_en})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: rtl/mac_vec_out.sv
// Dot-product stage feeding the output FIFO: multiply register, accumulator
// and a one-cycle write strobe, with credit control in mac_credit_ctrl.
module mac_vec_out
  import mac_vec_out_pkg::*;
#(
  parameter int INW   = DEF_INW,
  parameter int OUTW  = DEF_OUTW,
  parameter int K     = DEF_K,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic         clk,
  input logic         reset,
  mac_vec_out_if.slave bus
);

  localparam int CAPW = cap_width(DEPTH);

  logic                   accept;
  logic                   first;
  logic                   last;
  logic                   in_ready;
  logic signed [2*INW-1:0] prod;
  prod_flags_t            pflags;
  logic signed [OUTW-1:0] prod_ext;
  logic signed [OUTW-1:0] acc;
  logic signed [OUTW-1:0] acc_next;
  logic [OUTW-1:0]        fifo_data_q;
  logic                   fifo_wr_en_q;

  mac_credit_ctrl #(
    .K    (K),
    .CAPW (CAPW)
  ) u_credit (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (bus.in_valid),
    .fifo_wr_en    (fifo_wr_en_q),
    .fifo_capacity (bus.fifo_capacity),
    .in_ready      (in_ready),
    .accept        (accept),
    .first         (first),
    .last          (last)
  );

  assign bus.in_ready   = in_ready;
  assign bus.fifo_data  = fifo_data_q;
  assign bus.fifo_wr_en = fifo_wr_en_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prod   <= '0;
      pflags <= '0;
    end else begin
      pflags.valid <= accept;
      if (accept) begin
        prod         <= (2*INW)'($signed(bus.x_data)) * (2*INW)'($signed(bus.w_data));
        pflags.first <= first;
        pflags.last  <= last;
      end
    end
  end

  // Sign-extended product; the sum wraps modulo 2^OUTW by design.
  assign prod_ext = OUTW'(prod);

  always_comb begin
    acc_next = acc;
    if (pflags.first) begin
      acc_next = prod_ext;
    end else begin
      acc_next = acc + prod_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc          <= '0;
      fifo_data_q  <= '0;
      fifo_wr_en_q <= 1'b0;
    end else begin
      fifo_wr_en_q <= pflags.valid && pflags.last;
      if (pflags.valid) begin
        acc <= acc_next;
        if (pflags.last) begin
          fifo_data_q <= acc_next;
        end
      end
    end
  end

endmodule
